// File: rtl/or8.sv
// or8: eight-input OR gate with a clocked status monitor (registered OR, edges, sticky hits, active count)
module or8 #(
  parameter bit STICKY_EN = 1'b1,
  parameter int CNT_W     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             d0,
  input  logic             d1,
  input  logic             d2,
  input  logic             d3,
  input  logic             d4,
  input  logic             d5,
  input  logic             d6,
  input  logic             d7,
  input  logic             clr,
  output logic             out,
  output logic             out_q,
  output logic             out_rise,
  output logic             out_fall,
  output logic [7:0]       sticky,
  output logic [CNT_W-1:0] active_cnt
);
  logic [7:0] d;
  logic [3:0] pc;
  assign d   = {d7, d6, d5, d4, d3, d2, d1, d0};
  assign out = |d;
  // population count of the live inputs, 0..8
  always_comb begin
    pc = '0;
    for (int i = 0; i < 8; i++) pc = pc + {3'b000, d[i]};
  end
  // monitor registers; clr beats a same-edge hit, sticky stays 0 when disabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q      <= 1'b0;
      out_rise   <= 1'b0;
      out_fall   <= 1'b0;
      sticky     <= '0;
      active_cnt <= '0;
    end else begin
      out_q      <= out;
      out_rise   <= out & ~out_q;
      out_fall   <= ~out & out_q;
      active_cnt <= CNT_W'(pc);
      sticky     <= STICKY_EN ? (clr ? '0 : sticky | d) : '0;
    end
  end
endmodule

// File: tb/tb_or8.sv
// tb_or8: directed self-checking bench for or8 (sticky enabled and disabled instances)
`timescale 1ns/1ps
module tb_or8;
  logic clk = 1'b0, clk_en = 1'b0, rst_n = 1'b0, clr = 1'b0;
  logic [7:0] d = '0;
  logic o0, q0, r0, f0, o1, q1, r1, f1;
  logic [7:0] s0, s1;
  logic [3:0] c0, c1;
  int errors = 0, checks = 0;
  logic eq = 0, er = 0, ef = 0;
  logic [3:0] ec = 0;
  logic [7:0] es = 0;
  int hp[8] = '{12, 11, 10, 9, 8, 7, 4, 2};

  or8 u0 (.clk(clk), .rst_n(rst_n), .d0(d[0]), .d1(d[1]), .d2(d[2]), .d3(d[3]),
          .d4(d[4]), .d5(d[5]), .d6(d[6]), .d7(d[7]), .clr(clr), .out(o0),
          .out_q(q0), .out_rise(r0), .out_fall(f0), .sticky(s0), .active_cnt(c0));
  or8 #(.STICKY_EN(1'b0)) u1 (.clk(clk), .rst_n(rst_n), .d0(d[0]), .d1(d[1]), .d2(d[2]),
          .d3(d[3]), .d4(d[4]), .d5(d[5]), .d6(d[6]), .d7(d[7]), .clr(clr), .out(o1),
          .out_q(q1), .out_rise(r1), .out_fall(f1), .sticky(s1), .active_cnt(c1));

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, " out"}, {31'b0, o0}, {31'b0, |d});
    chk({tag, " out_q"}, {31'b0, q0}, {31'b0, eq});
    chk({tag, " rise"}, {31'b0, r0}, {31'b0, er});
    chk({tag, " fall"}, {31'b0, f0}, {31'b0, ef});
    chk({tag, " cnt"}, {28'b0, c0}, {28'b0, ec});
    chk({tag, " sticky"}, {24'b0, s0}, {24'b0, es});
    chk({tag, " u1 out_q"}, {31'b0, q1}, {31'b0, eq});
    chk({tag, " u1 rise"}, {31'b0, r1}, {31'b0, er});
    chk({tag, " u1 fall"}, {31'b0, f1}, {31'b0, ef});
    chk({tag, " u1 cnt"}, {28'b0, c1}, {28'b0, ec});
    chk({tag, " u1 sticky"}, {24'b0, s1}, 32'h0);
  endtask

  task automatic step(input logic [7:0] v, input logic c, input string tag);
    logic pq;
    @(negedge clk);
    d = v;
    clr = c;
    @(posedge clk);
    #1;
    pq = eq;
    eq = |v;
    er = eq & ~pq;
    ef = ~eq & pq;
    ec = 4'($countones(v));
    es = c ? 8'h00 : (es | v);
    check_all(tag);
  endtask

  initial begin
    #1;
    chk("comb zero", {31'b0, o0}, 32'h0);
    chk("reset out_q", {31'b0, q0}, 32'h0);
    chk("reset sticky", {24'b0, s0}, 32'h0);
    for (int i = 0; i < 8; i++) begin
      d = 8'h01 << i;
      #1;
      chk($sformatf("onehot d%0d", i), {31'b0, o0}, 32'h1);
      chk($sformatf("onehot u1 d%0d", i), {31'b0, o1}, 32'h1);
    end
    for (int t = 0; t < 200; t++) begin
      for (int i = 0; i < 8; i++) d[i] = ((t / hp[i]) % 2) == 1;
      #0.5;
      chk($sformatf("toggle t=%0d", t), {31'b0, o0}, {31'b0, |d});
      #0.5;
    end
    d = 8'h00;
    #1;
    rst_n = 1'b1;
    clk_en = 1'b1;
    step(8'h11, 1'b0, "pre-reset");
    chk("pre-reset cnt", {28'b0, c0}, 32'h2);
    @(posedge clk);
    #2;
    d = 8'hFF;
    rst_n = 1'b0;
    #1;
    eq = 0; er = 0; ef = 0; ec = 0; es = 0;
    chk("async rst out", {31'b0, o0}, 32'h1);
    chk("async rst out_q", {31'b0, q0}, 32'h0);
    chk("async rst cnt", {28'b0, c0}, 32'h0);
    chk("async rst sticky", {24'b0, s0}, 32'h0);
    rst_n = 1'b1;
    step(8'hFF, 1'b0, "post-reset");
    chk("post-reset rise", {31'b0, r0}, 32'h1);
    chk("post-reset cnt", {28'b0, c0}, 32'h8);
    step(8'h00, 1'b0, "fall FF");
    step(8'h04, 1'b0, "edge1");
    chk("edge rise", {31'b0, r0}, 32'h1);
    step(8'h04, 1'b0, "edge2");
    chk("edge rise once", {31'b0, r0}, 32'h0);
    step(8'h04, 1'b0, "edge3");
    chk("edge held q", {31'b0, q0}, 32'h1);
    step(8'h00, 1'b0, "edge4");
    chk("edge fall", {31'b0, f0}, 32'h1);
    step(8'h00, 1'b0, "edge5");
    chk("edge fall once", {31'b0, f0}, 32'h0);
    step(8'hA6, 1'b0, "cnt A6");
    chk("cnt 4", {28'b0, c0}, 32'h4);
    step(8'hFF, 1'b0, "cnt FF");
    chk("cnt 8", {28'b0, c0}, 32'h8);
    step(8'h00, 1'b0, "cnt 00");
    chk("cnt 0", {28'b0, c0}, 32'h0);
    step(8'h00, 1'b1, "sticky clr");
    step(8'h08, 1'b0, "sticky d3");
    step(8'h40, 1'b0, "sticky d6");
    step(8'h00, 1'b0, "sticky hold");
    chk("sticky 48", {24'b0, s0}, 32'h48);
    step(8'h01, 1'b1, "clr prio");
    chk("clr prio", {24'b0, s0}, 32'h0);
    step(8'h01, 1'b0, "sticky d0");
    chk("sticky 01", {24'b0, s0}, 32'h1);
    for (int k = 0; k < 24; k++)
      step(8'($urandom), ($urandom_range(0, 3) == 0), $sformatf("rand%0d", k));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
